dbg_bvci_arb: RTL and testbench
===============================

Name: dbg_bvci_arb

Overview:
Two-requester arbiter that shares the single debug BVCI target port (the debug BVCI-to-APB bridge) between the JTAG debug master (req 0) and the system-side debug master (req 1). Exactly one transaction is in flight at a time. Grants alternate round-robin, and each grant is held from command through response. A response watchdog returns an error to the requester if the target never responds, then drains the late response.

Parameters:
TIMEOUT, 1024, cycles in RSP without tgt_rspval before a synthetic error response; 0 disables the watchdog
CNT_W, 16, watchdog counter width; TIMEOUT must be < 2^CNT_W

Ports:
clk  in  1  core clock
rst_a  in  1  reset; asynchronous, active-high
req_cmdval  in  2  per-requester BVCI cmdval; bit n = requester n
req_cmdack  out  2  per-requester cmdack
req_address  in  64  {req1[31:0], req0[31:0]} byte address
req_be  in  8  {req1[3:0], req0[3:0]}
req_cmd  in  4  {req1[1:0], req0[1:0]}; 01 read, 10 write
req_wdata  in  64  {req1[31:0], req0[31:0]}
req_rspack  in  2  per-requester rspack
req_rspval  out  2  per-requester rspval
req_rdata  out  32  response data, shared by both requesters
req_reop  out  1  response eop, shared
req_rerr  out  1  response error, shared
tgt_cmdval  out  1  to target
tgt_cmdack  in  1  from target
tgt_address  out  32  muxed address
tgt_be  out  4  muxed byte enables
tgt_cmd  out  2  muxed command
tgt_wdata  out  32  muxed write data
tgt_rspval  in  1  from target
tgt_rspack  out  1  to target
tgt_rdata  in  32  from target
tgt_reop  in  1  from target
tgt_rerr  in  1  from target
arb_gnt  out  1  current or last grant index
arb_busy  out  1  high in any state other than IDLE
arb_timeout  out  1  single-cycle pulse on entry to ERR

Behaviour:
- Registered state: state_r (IDLE, CMD, RSP, ERR, DRAIN), gnt_r, last_r, cnt_r.
- Reset values: state_r=IDLE, gnt_r=0, last_r=1 (so req 0 wins the first tie), cnt_r=0.
- Outputs in reset: all valid/ack outputs 0, arb_busy=0, arb_timeout=0. Mux outputs follow gnt_r=0.
- IDLE:
  - Nothing is forwarded; req_cmdack=0, req_rspval=0, tgt_cmdval=0, tgt_rspack=0.
  - If any req_cmdval is high: gnt_r <= winner, state <= CMD. This costs one cycle of arbitration latency.
  - Winner: the only requester asserting cmdval; if both assert, the requester != last_r.
- CMD:
  - tgt_cmdval = req_cmdval[gnt_r]; tgt_address/be/cmd/wdata are muxed combinationally from gnt_r.
  - req_cmdack[gnt_r] = tgt_cmdack; the other requester's cmdack is 0.
  - On the cmdval&cmdack handshake: state <= RSP, cnt_r <= 0.
  - If req_cmdval[gnt_r] drops before the handshake (protocol violation): state <= IDLE, last_r unchanged.
- RSP:
  - req_rspval[gnt_r] = tgt_rspval; req_rdata/reop/rerr pass through from the target; tgt_rspack = req_rspack[gnt_r].
  - On the rspval&rspack handshake: last_r <= gnt_r, state <= IDLE.
  - Otherwise, if TIMEOUT != 0: cnt_r increments on every cycle with tgt_rspval=0.
  - When cnt_r == TIMEOUT-1 and tgt_rspval=0: state <= ERR and arb_timeout pulses.
  - tgt_rspval high in the same cycle as expiry takes priority: the real response is forwarded and no ERR occurs.
- ERR:
  - req_rspval[gnt_r]=1, req_rdata=0, req_reop=1, req_rerr=1; tgt_rspack=0.
  - On req_rspack[gnt_r]: last_r <= gnt_r, cnt_r <= 0, state <= DRAIN.
- DRAIN:
  - tgt_rspack=1; req_rspval=0; no grants are issued.
  - Exits to IDLE on the first tgt_rspval (the late response is discarded), or when cnt_r reaches TIMEOUT-1.
- Only one transaction is ever outstanding.
- Fairness: a requester that holds cmdval continuously is granted within one transaction of the other requester.
- Back-to-back: after a completed response the arbiter passes through IDLE, so the minimum gap is 1 cycle per transaction.
- Reset asserted mid-transaction: everything returns to its reset value immediately. The target side is not drained.

Decomposition:
- Shared package dbg_arb_pkg holds:
  - state encoding (IDLE=3'd0, CMD=1, RSP=2, ERR=3, DRAIN=4)
  - BVCI command codes (CMD_RD=2'b01, CMD_WR=2'b10)
  - field widths (ADDR 32, BE 4, DATA 32)
- One natural sub-module, dbg_arb_rr2: a 2-way round-robin pick taking req[1:0] and last, producing winner and any.

Test Plan:
- Single read: req0 read, address 0xFFFF0010. Target acks in 2 cycles and responds with rdata=0xA5A5_0001, rerr=0 → req_rspval[0] high with that data; req1 sees no rspval; last_r=0.
- Simultaneous requests: both cmdval high from reset → req0 served first, then req1 (its write data 0x1234_5678 appears on tgt_wdata); with both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- Back-to-back: req1 issues 3 writes with cmdval held → 3 target handshakes, with exactly 1 IDLE cycle between each response and the next tgt_cmdval.
- Timeout: TIMEOUT=8, target never asserts rspval → on the 8th RSP cycle arb_timeout pulses; the requester receives rspval with rerr=1, rdata=0; the arbiter enters DRAIN. A late tgt_rspval 3 cycles later is acked, not forwarded, and the arbiter returns to IDLE.
- Response coincident with expiry: TIMEOUT=4, tgt_rspval arrives in the 4th RSP cycle → normal response forwarded, arb_timeout stays 0.
- Reset mid-RSP: rst_a pulsed while in RSP → req_rspval=0, tgt_cmdval=0, arb_busy=0 in the same cycle; the next request is granted to req0.

Source files
------------

// File: rtl/dbg_arb_pkg.sv
// Shared types and constants for the debug BVCI two-requester arbiter.
package dbg_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 2;

    localparam logic [CMD_W-1:0] CMD_RD = 2'b01;
    localparam logic [CMD_W-1:0] CMD_WR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_RSP   = 3'd2,
        ST_ERR   = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   be;
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] wdata;
    } bvci_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              reop;
        logic              rerr;
    } bvci_rsp_t;

endpackage

// File: rtl/dbg_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module dbg_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dbg_bvci_arb.sv
// Shares the debug BVCI target between the JTAG and system debug masters,
// one transaction at a time, with a response watchdog and late-response drain.
module dbg_bvci_arb
    import dbg_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic [1:0]            req_cmdval,
    output logic [1:0]            req_cmdack,
    input  logic [2*ADDR_W-1:0]   req_address,
    input  logic [2*BE_W-1:0]     req_be,
    input  logic [2*CMD_W-1:0]    req_cmd,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [1:0]            req_rspack,
    output logic [1:0]            req_rspval,
    output logic [DATA_W-1:0]     req_rdata,
    output logic                  req_reop,
    output logic                  req_rerr,
    output logic                  tgt_cmdval,
    input  logic                  tgt_cmdack,
    output logic [ADDR_W-1:0]     tgt_address,
    output logic [BE_W-1:0]       tgt_be,
    output logic [CMD_W-1:0]      tgt_cmd,
    output logic [DATA_W-1:0]     tgt_wdata,
    input  logic                  tgt_rspval,
    output logic                  tgt_rspack,
    input  logic [DATA_W-1:0]     tgt_rdata,
    input  logic                  tgt_reop,
    input  logic                  tgt_rerr,
    output logic                  arb_gnt,
    output logic                  arb_busy,
    output logic                  arb_timeout
);

    localparam logic             WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rr_winner;
    logic             rr_any;
    bvci_cmd_t        cmd0_c, cmd1_c, cmd_sel_c;
    bvci_rsp_t        rsp_c;

    dbg_arb_rr2 u_rr2 (
        .req    (req_cmdval),
        .last   (last_q),
        .winner (rr_winner),
        .any    (rr_any)
    );

    // Command payload follows the current grant even when idle.
    assign cmd0_c    = {req_address[ADDR_W-1:0], req_be[BE_W-1:0],
                        req_cmd[CMD_W-1:0], req_wdata[DATA_W-1:0]};
    assign cmd1_c    = {req_address[2*ADDR_W-1:ADDR_W], req_be[2*BE_W-1:BE_W],
                        req_cmd[2*CMD_W-1:CMD_W], req_wdata[2*DATA_W-1:DATA_W]};
    assign cmd_sel_c = gnt_q ? cmd1_c : cmd0_c;

    assign tgt_address = cmd_sel_c.address;
    assign tgt_be      = cmd_sel_c.be;
    assign tgt_cmd     = cmd_sel_c.cmd;
    assign tgt_wdata   = cmd_sel_c.wdata;

    assign req_rdata = rsp_c.rdata;
    assign req_reop  = rsp_c.reop;
    assign req_rerr  = rsp_c.rerr;

    assign arb_gnt  = gnt_q;
    assign arb_busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        req_cmdack  = '0;
        req_rspval  = '0;
        tgt_cmdval  = 1'b0;
        tgt_rspack  = 1'b0;
        arb_timeout = 1'b0;
        rsp_c       = '{rdata: tgt_rdata, reop: tgt_reop, rerr: tgt_rerr};

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    gnt_d   = rr_winner;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                tgt_cmdval          = req_cmdval[gnt_q];
                req_cmdack[gnt_q]   = tgt_cmdack;
                // A requester withdrawing its command forfeits the grant.
                if (!req_cmdval[gnt_q]) begin
                    state_d = ST_IDLE;
                end else if (tgt_cmdack) begin
                    state_d = ST_RSP;
                    cnt_d   = '0;
                end
            end
            ST_RSP: begin
                req_rspval[gnt_q] = tgt_rspval;
                tgt_rspack        = req_rspack[gnt_q];
                // A real response wins over a watchdog expiry in the same cycle.
                if (tgt_rspval) begin
                    if (req_rspack[gnt_q]) begin
                        last_d  = gnt_q;
                        state_d = ST_IDLE;
                    end
                end else if (WDOG_EN) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_ERR;
                        arb_timeout = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                req_rspval[gnt_q] = 1'b1;
                rsp_c             = '{rdata: '0, reop: 1'b1, rerr: 1'b1};
                if (req_rspack[gnt_q]) begin
                    last_d  = gnt_q;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Swallow the late response so it never reaches a requester.
                tgt_rspack = 1'b1;
                if (tgt_rspval || (cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_bvci_arb.sv
// Directed scoreboard bench for dbg_bvci_arb; a TIMEOUT=4 copy shares the stimulus.
module tb_dbg_bvci_arb;
    import dbg_arb_pkg::*;

    localparam int unsigned TO_A = 8;
    localparam int unsigned TO_B = 4;

    logic        clk = 1'b0;
    logic        rst_a;
    logic [1:0]  req_cmdval;
    logic [1:0]  req_rspack;
    logic        tgt_cmdack;
    logic        tgt_rspval;
    logic [31:0] tgt_rdata;
    logic        tgt_reop;
    logic        tgt_rerr;

    logic [31:0] r_addr [2];
    logic [31:0] r_wdata[2];
    logic [3:0]  r_be   [2];
    logic [1:0]  r_cmd  [2];
    int          left   [2];

    logic [63:0] req_address;
    logic [7:0]  req_be;
    logic [3:0]  req_cmd;
    logic [63:0] req_wdata;

    assign req_address = {r_addr[1], r_addr[0]};
    assign req_be      = {r_be[1], r_be[0]};
    assign req_cmd     = {r_cmd[1], r_cmd[0]};
    assign req_wdata   = {r_wdata[1], r_wdata[0]};

    logic [1:0]  req_cmdack, req_rspval, b_req_cmdack, b_req_rspval;
    logic [31:0] req_rdata, b_req_rdata;
    logic        req_reop, req_rerr, b_req_reop, b_req_rerr;
    logic        tgt_cmdval, tgt_rspack, b_tgt_cmdval, b_tgt_rspack;
    logic [31:0] tgt_address, tgt_wdata, b_tgt_address, b_tgt_wdata;
    logic [3:0]  tgt_be, b_tgt_be;
    logic [1:0]  tgt_cmd, b_tgt_cmd;
    logic        arb_gnt, arb_busy, arb_timeout, b_arb_gnt, b_arb_busy, b_arb_timeout;

    dbg_bvci_arb #(.TIMEOUT(TO_A), .CNT_W(16)) dut (
        .clk(clk), .rst_a(rst_a),
        .req_cmdval(req_cmdval), .req_cmdack(req_cmdack),
        .req_address(req_address), .req_be(req_be), .req_cmd(req_cmd), .req_wdata(req_wdata),
        .req_rspack(req_rspack), .req_rspval(req_rspval),
        .req_rdata(req_rdata), .req_reop(req_reop), .req_rerr(req_rerr),
        .tgt_cmdval(tgt_cmdval), .tgt_cmdack(tgt_cmdack),
        .tgt_address(tgt_address), .tgt_be(tgt_be), .tgt_cmd(tgt_cmd), .tgt_wdata(tgt_wdata),
        .tgt_rspval(tgt_rspval), .tgt_rspack(tgt_rspack),
        .tgt_rdata(tgt_rdata), .tgt_reop(tgt_reop), .tgt_rerr(tgt_rerr),
        .arb_gnt(arb_gnt), .arb_busy(arb_busy), .arb_timeout(arb_timeout)
    );

    dbg_bvci_arb #(.TIMEOUT(TO_B), .CNT_W(16)) dut_b (
        .clk(clk), .rst_a(rst_a),
        .req_cmdval(req_cmdval), .req_cmdack(b_req_cmdack),
        .req_address(req_address), .req_be(req_be), .req_cmd(req_cmd), .req_wdata(req_wdata),
        .req_rspack(req_rspack), .req_rspval(b_req_rspval),
        .req_rdata(b_req_rdata), .req_reop(b_req_reop), .req_rerr(b_req_rerr),
        .tgt_cmdval(b_tgt_cmdval), .tgt_cmdack(tgt_cmdack),
        .tgt_address(b_tgt_address), .tgt_be(b_tgt_be), .tgt_cmd(b_tgt_cmd), .tgt_wdata(b_tgt_wdata),
        .tgt_rspval(tgt_rspval), .tgt_rspack(b_tgt_rspack),
        .tgt_rdata(tgt_rdata), .tgt_reop(tgt_reop), .tgt_rerr(tgt_rerr),
        .arb_gnt(b_arb_gnt), .arb_busy(b_arb_busy), .arb_timeout(b_arb_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        gnt;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [1:0]  cmd;
        logic [31:0] wdata;
    } exp_cmd_t;

    typedef struct {
        logic        gnt;
        logic [31:0] rdata;
        logic        rerr;
    } exp_rsp_t;

    exp_cmd_t cmd_q[$];
    exp_rsp_t rsp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int last_rsp_cyc = 0;
    int idle_gap     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [1:0] c,
                           input logic [31:0] wd, input int n);
        r_addr[r]  = a;
        r_cmd[r]   = c;
        r_wdata[r] = wd;
        r_be[r]    = (r == 0) ? 4'hF : 4'h3;
        left[r]    = n;
    endtask

    task automatic expect_txn(input logic g, input logic [31:0] a, input logic [3:0] be,
                              input logic [1:0] c, input logic [31:0] wd,
                              input logic [31:0] rd, input logic re);
        exp_cmd_t ec;
        exp_rsp_t er;
        ec.gnt = g; ec.addr = a; ec.be = be; ec.cmd = c; ec.wdata = wd;
        er.gnt = g; er.rdata = rd; er.rerr = re;
        cmd_q.push_back(ec);
        rsp_q.push_back(er);
    endtask

    // Plays the target for one transaction and scores both its phases.
    task automatic serve(input int ack_dly, input int rsp_dly, input logic [31:0] rdata,
                         input logic rerr, input logic chk_b);
        exp_cmd_t ec;
        exp_rsp_t er;
        int       n;
        int       g;
        logic     to_a;
        logic     to_b;
        n = 0;
        while (tgt_cmdval !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("cmdval_wait", 32'(tgt_cmdval), 32'(1));
        idle_gap = cyc - last_rsp_cyc;
        ec = cmd_q.pop_front();
        g  = int'(ec.gnt);
        repeat (ack_dly) tick();
        tgt_cmdack = 1'b1;
        #1;
        chk("gnt",     32'(arb_gnt),     32'(ec.gnt));
        chk("address", tgt_address,      ec.addr);
        chk("be",      32'(tgt_be),      32'(ec.be));
        chk("cmd",     32'(tgt_cmd),     32'(ec.cmd));
        chk("wdata",   tgt_wdata,        ec.wdata);
        chk("cmdack",  32'(req_cmdack),  32'(1) << g);
        if (chk_b) begin
            chk("b_cmdval",  32'(b_tgt_cmdval), 32'(1));
            chk("b_gnt",     32'(b_arb_gnt),    32'(ec.gnt));
            chk("b_address", b_tgt_address,     ec.addr);
            chk("b_be",      32'(b_tgt_be),     32'(ec.be));
            chk("b_cmd",     32'(b_tgt_cmd),    32'(ec.cmd));
            chk("b_wdata",   b_tgt_wdata,       ec.wdata);
            chk("b_cmdack",  32'(b_req_cmdack), 32'(1) << g);
        end
        tick();
        tgt_cmdack = 1'b0;
        left[g]--;
        if (left[g] == 0) req_cmdval[g] = 1'b0;
        else if (r_cmd[g] == CMD_WR) r_wdata[g] = r_wdata[g] + 32'd1;
        to_a = 1'b0;
        to_b = 1'b0;
        repeat (rsp_dly) begin
            #1;
            to_a = to_a | arb_timeout;
            to_b = to_b | b_arb_timeout;
            tick();
        end
        tgt_rspval = 1'b1;
        tgt_rdata  = rdata;
        tgt_rerr   = rerr;
        tgt_reop   = 1'b1;
        #1;
        to_a = to_a | arb_timeout;
        to_b = to_b | b_arb_timeout;
        er = rsp_q.pop_front();
        chk("rspval",     32'(req_rspval), 32'(1) << int'(er.gnt));
        chk("rdata",      req_rdata,       er.rdata);
        chk("rerr",       32'(req_rerr),   32'(er.rerr));
        chk("reop",       32'(req_reop),   32'(1));
        chk("tgt_rspack", 32'(tgt_rspack), 32'(1));
        chk("no_timeout", 32'(to_a),       32'(0));
        if (chk_b) begin
            chk("b_rspval",     32'(b_req_rspval), 32'(1) << int'(er.gnt));
            chk("b_rdata",      b_req_rdata,       er.rdata);
            chk("b_rerr",       32'(b_req_rerr),   32'(er.rerr));
            chk("b_reop",       32'(b_req_reop),   32'(1));
            chk("b_tgt_rspack", 32'(b_tgt_rspack), 32'(1));
            chk("b_busy",       32'(b_arb_busy),   32'(1));
            chk("b_no_timeout", 32'(to_b),         32'(0));
        end
        tick();
        last_rsp_cyc = cyc;
        tgt_rspval = 1'b0;
    endtask

    initial begin
        int n;
        logic to_a;
        exp_rsp_t er;
        rst_a      = 1'b1;
        req_cmdval = 2'b00;
        req_rspack = 2'b11;
        tgt_cmdack = 1'b0;
        tgt_rspval = 1'b0;
        tgt_rdata  = '0;
        tgt_reop   = 1'b0;
        tgt_rerr   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_be[i] = '0; r_cmd[i] = '0; left[i] = 0;
        end
        repeat (2) tick();

        // Reset state
        chk("rst_cmdack",  32'(req_cmdack),  32'(0));
        chk("rst_rspval",  32'(req_rspval),  32'(0));
        chk("rst_tcmdval", 32'(tgt_cmdval),  32'(0));
        chk("rst_trspack", 32'(tgt_rspack),  32'(0));
        chk("rst_busy",    32'(arb_busy),    32'(0));
        chk("rst_timeout", 32'(arb_timeout), 32'(0));
        chk("rst_gnt",     32'(arb_gnt),     32'(0));
        rst_a = 1'b0;
        tick();

        // Single read from req 0
        set_req(0, 32'hFFFF_0010, CMD_RD, 32'h0, 1);
        expect_txn(1'b0, 32'hFFFF_0010, 4'hF, CMD_RD, 32'h0, 32'hA5A5_0001, 1'b0);
        req_cmdval[0] = 1'b1;
        serve(1, 1, 32'hA5A5_0001, 1'b0, 1'b0);

        // Both requesting from reset: alternate 0,1,0,1
        do_reset();
        set_req(0, 32'h0000_0100, CMD_RD, 32'h0, 2);
        set_req(1, 32'h0000_0200, CMD_WR, 32'h1234_5678, 2);
        expect_txn(1'b0, 32'h0000_0100, 4'hF, CMD_RD, 32'h0,         32'h0000_1111, 1'b0);
        expect_txn(1'b1, 32'h0000_0200, 4'h3, CMD_WR, 32'h1234_5678, 32'h0000_2222, 1'b0);
        expect_txn(1'b0, 32'h0000_0100, 4'hF, CMD_RD, 32'h0,         32'h0000_3333, 1'b1);
        expect_txn(1'b1, 32'h0000_0200, 4'h3, CMD_WR, 32'h1234_5679, 32'h0000_4444, 1'b0);
        req_cmdval = 2'b11;
        serve(0, 0, 32'h0000_1111, 1'b0, 1'b0);
        serve(1, 2, 32'h0000_2222, 1'b0, 1'b0);
        serve(0, 1, 32'h0000_3333, 1'b1, 1'b0);
        serve(2, 0, 32'h0000_4444, 1'b0, 1'b0);

        // Back-to-back writes from req 1: one IDLE cycle between transactions
        set_req(1, 32'h0000_0300, CMD_WR, 32'hC0DE_0000, 3);
        for (int k = 0; k < 3; k++)
            expect_txn(1'b1, 32'h0000_0300, 4'h3, CMD_WR, 32'hC0DE_0000 + 32'(k), 32'(k), 1'b0);
        req_cmdval[1] = 1'b1;
        serve(0, 0, 32'h0, 1'b0, 1'b0);
        serve(0, 0, 32'h1, 1'b0, 1'b0);
        chk("b2b_gap1", 32'(idle_gap), 32'(1));
        serve(0, 0, 32'h2, 1'b0, 1'b0);
        chk("b2b_gap2", 32'(idle_gap), 32'(1));

        // Response arriving in the expiry cycle (TIMEOUT=8, 8th RSP cycle)
        set_req(0, 32'h0000_0400, CMD_RD, 32'h0, 1);
        expect_txn(1'b0, 32'h0000_0400, 4'hF, CMD_RD, 32'h0, 32'h0000_0B0B, 1'b0);
        req_cmdval[0] = 1'b1;
        serve(0, 7, 32'h0000_0B0B, 1'b0, 1'b0);

        // Watchdog expiry, error response, then drain of a late response
        set_req(0, 32'h0000_0500, CMD_RD, 32'h0, 1);
        er.gnt = 1'b0; er.rdata = 32'h0; er.rerr = 1'b1;
        rsp_q.push_back(er);
        req_cmdval[0] = 1'b1;
        n = 0;
        while (tgt_cmdval !== 1'b1 && n < 40) begin tick(); n++; end
        chk("to_cmdval", 32'(tgt_cmdval), 32'(1));
        tgt_cmdack = 1'b1;
        #1;
        chk("to_address", tgt_address, 32'h0000_0500);
        tick();
        tgt_cmdack = 1'b0;
        req_cmdval[0] = 1'b0;
        left[0] = 0;
        to_a = 1'b0;
        for (int k = 1; k < int'(TO_A); k++) begin
            #1;
            to_a = to_a | arb_timeout;
            tick();
        end
        #1;
        chk("to_early",  32'(to_a),        32'(0));
        chk("to_pulse",  32'(arb_timeout), 32'(1));
        chk("to_nofwd",  32'(req_rspval),  32'(0));
        tick();
        er = rsp_q.pop_front();
        chk("err_rspval",  32'(req_rspval),  32'(1) << int'(er.gnt));
        chk("err_rdata",   req_rdata,        er.rdata);
        chk("err_rerr",    32'(req_rerr),    32'(er.rerr));
        chk("err_reop",    32'(req_reop),    32'(1));
        chk("err_trspack", 32'(tgt_rspack),  32'(0));
        chk("err_pulse",   32'(arb_timeout), 32'(0));
        tick();
        chk("drn_rspval",  32'(req_rspval), 32'(0));
        chk("drn_trspack", 32'(tgt_rspack), 32'(1));
        chk("drn_busy",    32'(arb_busy),   32'(1));
        repeat (2) tick();
        tgt_rspval = 1'b1;
        tgt_rdata  = 32'hDEAD_BEEF;
        tgt_reop   = 1'b1;
        #1;
        chk("late_nofwd",  32'(req_rspval), 32'(0));
        chk("late_ack",    32'(tgt_rspack), 32'(1));
        tick();
        tgt_rspval = 1'b0;
        #1;
        chk("drn_idle",    32'(arb_busy),   32'(0));

        // Reset while a response is pending
        set_req(1, 32'h0000_0600, CMD_WR, 32'h6666_0000, 1);
        req_cmdval[1] = 1'b1;
        n = 0;
        while (tgt_cmdval !== 1'b1 && n < 40) begin tick(); n++; end
        chk("mr_cmdval", 32'(tgt_cmdval), 32'(1));
        tgt_cmdack = 1'b1;
        tick();
        tgt_cmdack = 1'b0;
        req_cmdval[1] = 1'b0;
        left[1] = 0;
        tick();
        chk("mr_busy_pre", 32'(arb_busy), 32'(1));
        rst_a = 1'b1;
        #1;
        chk("mr_rspval",  32'(req_rspval), 32'(0));
        chk("mr_tcmdval", 32'(tgt_cmdval), 32'(0));
        chk("mr_busy",    32'(arb_busy),   32'(0));
        tick();
        rst_a = 1'b0;
        tick();
        set_req(0, 32'h0000_0700, CMD_RD, 32'h0, 1);
        set_req(1, 32'h0000_0800, CMD_WR, 32'h8888_0000, 1);
        expect_txn(1'b0, 32'h0000_0700, 4'hF, CMD_RD, 32'h0,         32'h0000_0707, 1'b0);
        expect_txn(1'b1, 32'h0000_0800, 4'h3, CMD_WR, 32'h8888_0000, 32'h0000_0808, 1'b0);
        req_cmdval = 2'b11;
        serve(0, 0, 32'h0000_0707, 1'b0, 1'b1);
        serve(0, 1, 32'h0000_0808, 1'b0, 1'b1);

        // Response coincident with expiry on the TIMEOUT=4 copy
        set_req(1, 32'h0000_0900, CMD_WR, 32'h9999_0000, 1);
        expect_txn(1'b1, 32'h0000_0900, 4'h3, CMD_WR, 32'h9999_0000, 32'h0000_0909, 1'b0);
        req_cmdval[1] = 1'b1;
        serve(0, int'(TO_B) - 1, 32'h0000_0909, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
